// File: rtl/mul32_seq_ctrl_if.sv
// Operand/result bundle for the sequential multiplier.
//   master : drives op_start, op_clear, multiplicand, multiplier; observes result, op_done, busy
//   slave  : the multiplier controller side
interface mul32_seq_ctrl_if;
    logic        op_start;
    logic        op_clear;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] result;
    logic        op_done;
    logic        busy;

    modport master (
        output op_start, op_clear, multiplicand, multiplier,
        input  result, op_done, busy
    );

    modport slave (
        input  op_start, op_clear, multiplicand, multiplier,
        output result, op_done, busy
    );
endinterface

// File: rtl/mul32_seq_ctrl.sv
// Sequential 32x32 unsigned shift-add multiplier.
// One 33-bit carry-lookahead add per clock over 32 iterations yields a 64-bit product.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : slave side of mul32_seq_ctrl_if (start/clear, operands, result/op_done/busy)

// Flat carry-lookahead adder: every carry is a sum-of-products of the bit
// generate/propagate terms, so no carry ripples through earlier carries.
module cla33 (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        ci,
    output logic [32:0] sum
);
    logic [31:0] g;
    logic [32:0] p;
    logic [32:0] c;

    always_comb begin
        g = a[31:0] & b[31:0];
        p = a ^ b;
        c = '0;
        c[0] = ci;
        for (int i = 1; i <= 32; i++) begin
            logic term;
            // Carry-in propagated all the way from bit 0.
            term = ci;
            for (int k = 0; k < i; k++) term = term & p[k];
            c[i] = term;
            // Carry generated at bit j and propagated through j+1..i-1.
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
        sum = p ^ c;
    end
endmodule

module mul32_seq_ctrl (
    input logic             clk,
    input logic             reset_n,
    mul32_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] prod_q, prod_d;
    logic [4:0]  count_q, count_d;

    logic [32:0] add_sum;
    logic [32:0] hi;

    cla33 u_cla33 (
        .a   ({1'b0, prod_q[63:32]}),
        .b   ({1'b0, mcand_q}),
        .ci  (1'b0),
        .sum (add_sum)
    );

    // Keep the adder carry as bit 32 of the upper half before shifting right.
    assign hi = prod_q[0] ? add_sum : {1'b0, prod_q[63:32]};

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        count_d = count_q;
        if (bus.op_clear) begin
            state_d = StIdle;
            mcand_d = '0;
            prod_d  = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.op_start) begin
                        mcand_d = bus.multiplicand;
                        prod_d  = {32'h0, bus.multiplier};
                        count_d = '0;
                        state_d = StExec;
                    end
                end
                StExec: begin
                    prod_d  = {hi, prod_q[31:1]};
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) state_d = StDone;
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            mcand_q <= '0;
            prod_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            count_q <= count_d;
        end
    end

    assign bus.result  = prod_q;
    assign bus.op_done = (state_q == StDone);
    assign bus.busy    = (state_q == StExec);
endmodule
